// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command encodings, refresh executor states and the ns-to-cycle helper.
package sdram_pkg;

    // Command pins {cs_n, ras_n, cas_n, we_n}.
    typedef enum logic [3:0] {
        CMD_MRS          = 4'b0000,
        CMD_AUTO_REFRESH = 4'b0001,
        CMD_PRECHARGE    = 4'b0010,
        CMD_ACTIVE       = 4'b0011,
        CMD_WRITE        = 4'b0100,
        CMD_READ         = 4'b0101,
        CMD_NOP          = 4'b0111
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_PRECHARGE,
        ST_WAIT_RP,
        ST_REFRESH,
        ST_WAIT_RFC,
        ST_DONE
    } refresh_state_t;

    // Rounds up to whole clock cycles; never returns less than one cycle.
    function automatic int ns_to_cycles(input int ns, input int mhz);
        int c;
        c = (ns * mhz + 999) / 1000;
        return c < 1 ? 1 : c;
    endfunction

endpackage

// File: rtl/sdram_wait_timer.sv
// sdram_wait_timer: loadable down-counter with a done flag, shared by the tRP and tRFC waits.
// Ports: clock, reset (async, active-high), load/load_value restart the count,
//        done is high while the count is zero.
module sdram_wait_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset)
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;

    assign done = count == '0;

endmodule

// File: rtl/sdram_refresh_executor.sv
// sdram_refresh_executor: answers refresh requests by issuing PRECHARGE ALL then AUTO REFRESH bursts.
// Ports: clock, reset (async, active-high), init_done, refresh_request/refresh_response handshake,
//        bus_request/bus_grant command-bus arbitration, sdram_command {cs_n,ras_n,cas_n,we_n},
//        sdram_a10, busy. Optional build macro REFRESH_STATS_EN adds refresh_done_count and
//        grant_wait_max.
module sdram_refresh_executor
    import sdram_pkg::*;
#(
    parameter int CLOCK_FREQUENCY_MHZ = 100,
    parameter int T_RP_NS             = 20,
    parameter int T_RFC_NS            = 66,
    parameter int REFRESH_BURST       = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        init_done,
    input  logic        refresh_request,
    output logic        refresh_response,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic [3:0]  sdram_command,
    output logic        sdram_a10,
    output logic        busy
`ifdef REFRESH_STATS_EN
    ,
    output logic [15:0] refresh_done_count,
    output logic [15:0] grant_wait_max
`endif
);

    localparam int T_RP_CYCLES  = ns_to_cycles(T_RP_NS, CLOCK_FREQUENCY_MHZ);
    localparam int T_RFC_CYCLES = ns_to_cycles(T_RFC_NS, CLOCK_FREQUENCY_MHZ);
    localparam int WW = $clog2((T_RP_CYCLES > T_RFC_CYCLES ? T_RP_CYCLES : T_RFC_CYCLES) + 1);
    localparam int BW = $clog2(REFRESH_BURST + 1);
    // A wait state lasts T-1 cycles and exits once the timer reads zero, so it is loaded with T-2.
    localparam int RP_LOAD  = T_RP_CYCLES > 1 ? T_RP_CYCLES - 2 : 0;
    localparam int RFC_LOAD = T_RFC_CYCLES > 1 ? T_RFC_CYCLES - 2 : 0;

    refresh_state_t  state, state_next, after_refresh;
    logic [BW-1:0]   burst_count;
    logic            wait_load, wait_done;
    logic [WW-1:0]   wait_value;

    always_comb begin
        after_refresh = burst_count < BW'(REFRESH_BURST) ? ST_REFRESH : ST_DONE;
        state_next    = state;
        case (state)
            ST_IDLE:      state_next = refresh_request && init_done ? ST_ARB : ST_IDLE;
            ST_ARB:       state_next = bus_grant ? ST_PRECHARGE : !refresh_request ? ST_IDLE : ST_ARB;
            ST_PRECHARGE: state_next = T_RP_CYCLES > 1 ? ST_WAIT_RP : ST_REFRESH;
            ST_WAIT_RP:   state_next = wait_done ? ST_REFRESH : ST_WAIT_RP;
            ST_REFRESH:   state_next = T_RFC_CYCLES > 1 ? ST_WAIT_RFC : after_refresh;
            ST_WAIT_RFC:  state_next = wait_done ? after_refresh : ST_WAIT_RFC;
            ST_DONE:      state_next = refresh_request ? ST_DONE : ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    assign wait_load  = state_next != state && (state_next == ST_WAIT_RP || state_next == ST_WAIT_RFC);
    assign wait_value = state_next == ST_WAIT_RP ? WW'(RP_LOAD) : WW'(RFC_LOAD);

    sdram_wait_timer #(.WIDTH(WW)) u_wait_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (wait_load),
        .load_value (wait_value),
        .done       (wait_done)
    );

    // Outputs are registered from the next state so each command lines up with its state.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state            <= ST_IDLE;
            burst_count      <= '0;
            refresh_response <= 1'b0;
            bus_request      <= 1'b0;
            sdram_command    <= CMD_NOP;
            sdram_a10        <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_next;
            burst_count      <= state_next == ST_IDLE ? '0 :
                                state_next == ST_REFRESH ? burst_count + 1'b1 : burst_count;
            refresh_response <= state_next == ST_DONE;
            bus_request      <= state_next inside {ST_ARB, ST_PRECHARGE, ST_WAIT_RP, ST_REFRESH, ST_WAIT_RFC};
            sdram_command    <= state_next == ST_PRECHARGE ? CMD_PRECHARGE :
                                state_next == ST_REFRESH ? CMD_AUTO_REFRESH : CMD_NOP;
            sdram_a10        <= state_next == ST_PRECHARGE;
            busy             <= state_next != ST_IDLE;
        end

`ifdef REFRESH_STATS_EN
    logic [15:0] arb_cycles, arb_next;

    // Running count of ARB cycles for the current arbitration, saturating.
    assign arb_next = state != ST_ARB ? 16'd1 : &arb_cycles ? arb_cycles : arb_cycles + 16'd1;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            arb_cycles         <= '0;
            refresh_done_count <= '0;
            grant_wait_max     <= '0;
        end else begin
            if (state_next == ST_DONE && state != ST_DONE)
                refresh_done_count <= refresh_done_count + 16'd1;
            if (state_next == ST_ARB) begin
                arb_cycles <= arb_next;
                if (arb_next > grant_wait_max)
                    grant_wait_max <= arb_next;
            end
        end
`endif

endmodule

// File: tb/tb_sdram_refresh_executor.sv
// tb_sdram_refresh_executor: directed and randomized refresh sequences checked against a timeline model.
module tb_sdram_refresh_executor;

    localparam int MHZ  = 100;
    localparam int TRP  = (20 * MHZ + 999) / 1000 < 1 ? 1 : (20 * MHZ + 999) / 1000;
    localparam int TRFC = (66 * MHZ + 999) / 1000 < 1 ? 1 : (66 * MHZ + 999) / 1000;
    localparam logic [7:0] IDLE_VEC = 8'b0001_1100;

    logic clock = 1'b0;
    logic reset;
    logic init_done = 1'b0, req1 = 1'b0, req3 = 1'b0, bus_grant = 1'b0;
    logic resp1, breq1, a10_1, busy1, resp3, breq3, a10_3, busy3;
    logic [3:0] cmd1, cmd3;
    int compared = 0, mismatched = 0;
    int exp_cnt[4], exp_max[4];
`ifdef REFRESH_STATS_EN
    logic [15:0] cnt1, max1, cnt3, max3;
`endif

    always #5 clock = ~clock;

    sdram_refresh_executor dut1 (
        .clock(clock), .reset(reset), .init_done(init_done), .refresh_request(req1),
        .refresh_response(resp1), .bus_request(breq1), .bus_grant(bus_grant),
        .sdram_command(cmd1), .sdram_a10(a10_1), .busy(busy1)
`ifdef REFRESH_STATS_EN
        , .refresh_done_count(cnt1), .grant_wait_max(max1)
`endif
    );

    sdram_refresh_executor #(.REFRESH_BURST(3)) dut3 (
        .clock(clock), .reset(reset), .init_done(init_done), .refresh_request(req3),
        .refresh_response(resp3), .bus_request(breq3), .bus_grant(bus_grant),
        .sdram_command(cmd3), .sdram_a10(a10_3), .busy(busy3)
`ifdef REFRESH_STATS_EN
        , .refresh_done_count(cnt3), .grant_wait_max(max3)
`endif
    );

    function automatic logic [7:0] obs(int inst);
        return inst == 3 ? {resp3, breq3, cmd3, a10_3, busy3} : {resp1, breq1, cmd1, a10_1, busy1};
    endfunction

    // Expected {response, bus_request, command, a10, busy} after edge e of a sequence whose
    // PRECHARGE lands on edge p, DONE on edge dn and return to IDLE on edge r.
    function automatic logic [7:0] model(int e, int p, int dn, int r, int b);
        logic [3:0] c;
        c = 4'b0111;
        if (e == p) c = 4'b0010;
        for (int i = 0; i < b; i++)
            if (e == p + TRP + i * TRFC) c = 4'b0001;
        return {e >= dn && e < r, e >= 1 && e < dn, c, e == p, e >= 1 && e < r};
    endfunction

    task automatic check(string tag, logic [15:0] o, logic [15:0] x);
        compared++;
        assert (o === x) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    // d: ARB cycles with grant low; q: last edge that samples request high;
    // gdrop/idrop: first edge where grant/init_done read low; abort_e: edge after which reset hits.
    task automatic do_seq(int inst, int d, int q, int gdrop, int idrop, int abort_e);
        int b, p, dn, r;
        b  = inst == 3 ? 3 : 1;
        p  = 2 + d;
        dn = p + TRP + b * TRFC;
        r  = q + 1 > dn + 1 ? q + 1 : dn + 1;
        if (d + 1 > exp_max[inst]) exp_max[inst] = d + 1;
        for (int e = 1; e <= r + 1; e++) begin
            if (inst == 3) req3 = e <= q; else req1 = e <= q;
            bus_grant = e >= 2 + d && e < gdrop;
            init_done = e < idrop;
            @(posedge clock);
            #1;
            check($sformatf("seq inst%0d d%0d e%0d", inst, d, e), 16'(obs(inst)), 16'(model(e, p, dn, r, b)));
            if (e == dn) exp_cnt[inst]++;
            if (e == abort_e) begin
                req1 = 1'b0;
                req3 = 1'b0;
                #3 reset = 1'b1;
                #1 check($sformatf("async reset inst%0d", inst), 16'(obs(inst)), 16'(IDLE_VEC));
                @(posedge clock);
                #2 reset = 1'b0;
                bus_grant = 1'b0;
                init_done = 1'b1;
                exp_cnt = '{default: 0};
                exp_max = '{default: 0};
                return;
            end
        end
        req1 = 1'b0;
        req3 = 1'b0;
        bus_grant = 1'b0;
        init_done = 1'b1;
    endtask

    task automatic check_stats(string tag);
`ifdef REFRESH_STATS_EN
        check({tag, " count1"}, cnt1, 16'(exp_cnt[1]));
        check({tag, " max1"}, max1, 16'(exp_max[1]));
        check({tag, " count3"}, cnt3, 16'(exp_cnt[3]));
        check({tag, " max3"}, max3, 16'(exp_max[3]));
`else
        check({tag, " idle1"}, 16'(obs(1)), 16'(IDLE_VEC));
`endif
    endtask

    initial begin
        exp_cnt = '{default: 0};
        exp_max = '{default: 0};
        reset = 1'b1;
        #1 check("reset async1", 16'(obs(1)), 16'(IDLE_VEC));
        check("reset async3", 16'(obs(3)), 16'(IDLE_VEC));
        req1 = 1'b1;
        bus_grant = 1'b1;
        init_done = 1'b1;
        repeat (3) @(posedge clock);
        #1 check("reset held1", 16'(obs(1)), 16'(IDLE_VEC));
        check_stats("reset");
        req1 = 1'b0;
        bus_grant = 1'b0;
        #1 reset = 1'b0;
        @(posedge clock);
        #1 check("post reset idle", 16'(obs(1)), 16'(IDLE_VEC));

        // Default timing, then grant delays 4 and 2 for the statistics.
        do_seq(1, 0, 13, 999, 999, 0);
        do_seq(1, 4, 16, 999, 999, 0);
        do_seq(1, 2, 9, 999, 999, 0);
        check_stats("three requests");

        do_seq(1, 5, 20, 999, 999, 0);
        do_seq(3, 0, 26, 999, 999, 0);

        // Request withdrawn while still arbitrating: no command, back to IDLE.
        req1 = 1'b1;
        bus_grant = 1'b0;
        @(posedge clock);
        #1 check("arb abort e1", 16'(obs(1)), 16'h005D);
        @(posedge clock);
        #1 check("arb abort e2", 16'(obs(1)), 16'h005D);
        req1 = 1'b0;
        if (exp_max[1] < 2) exp_max[1] = 2;
        @(posedge clock);
        #1 check("arb abort idle", 16'(obs(1)), 16'(IDLE_VEC));

        // No refresh before init completes.
        init_done = 1'b0;
        req1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1 check($sformatf("no init c%0d", i), 16'(obs(1)), 16'(IDLE_VEC));
        end
        do_seq(1, 0, 12, 999, 999, 0);

        // Reset during WAIT_RFC, then a full fresh sequence.
        do_seq(1, 0, 20, 999, 999, 6);
        @(posedge clock);
        #1 check("after abort idle", 16'(obs(1)), 16'(IDLE_VEC));
        do_seq(1, 0, 11, 999, 999, 0);

        for (int k = 0; k < 16; k++) begin
            int inst, d, b, p, dn, q, gdrop, idrop;
            inst  = $urandom_range(0, 1) ? 3 : 1;
            d     = $urandom_range(0, 6);
            b     = inst == 3 ? 3 : 1;
            p     = 2 + d;
            dn    = p + TRP + b * TRFC;
            q     = $urandom_range(p, dn + 3);
            gdrop = $urandom_range(0, 1) ? $urandom_range(p + 1, dn) : 999;
            idrop = $urandom_range(0, 1) ? $urandom_range(p + 1, dn + 2) : 999;
            repeat ($urandom_range(0, 2)) @(posedge clock);
            do_seq(inst, d, q, gdrop, idrop, 0);
        end
        check_stats("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
